// File: rtl/onehot_strobe_decoder_if.sv
// ============================================================================
// Module      : onehot_strobe_decoder_if
// Description : Code handshake and strobe bundle for onehot_strobe_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface onehot_strobe_decoder_if #(
    parameter int IN_W = 3
);
    localparam int OUT_W = 2 ** IN_W;

    logic             in_valid;
    logic [IN_W-1:0]  in;
    logic             in_ready;
    logic             abort;
    logic [OUT_W-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in, abort,
        input  in_ready, out, busy, done
    );

    modport slave (
        input  in_valid, in, abort,
        output in_ready, out, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/onehot_strobe_decoder.sv
// ============================================================================
// Module      : onehot_strobe_decoder
// Description : Binary code -> one-hot strobe held for DWELL cycles, then a
//               GAP-cycle blanking interval. ONEHOT_STROBE_SKID_EN adds a
//               one-entry pending register for back-to-back codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_strobe_decoder #(
    parameter int IN_W  = 3,
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    onehot_strobe_decoder_if.slave  bus
);
    localparam int OUT_W = 2 ** IN_W;

    localparam logic [7:0]       c_dwell_ld = 8'(DWELL - 1);
    localparam logic [7:0]       c_gap_ld   = 8'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [OUT_W-1:0] c_one      = OUT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [IN_W-1:0]  r_code, w_code_nxt;
    logic [OUT_W-1:0] r_out;
    logic             r_busy;
    logic             r_done;
    logic             w_ready;
    logic             w_take;
    logic             w_finish;

`ifdef ONEHOT_STROBE_SKID_EN
    logic             r_pend_full, w_pend_full_nxt;
    logic [IN_W-1:0]  r_pend_code, w_pend_code_nxt;

    assign w_ready = rst_n && ((r_state == S_IDLE) || !r_pend_full);
`else
    assign w_ready = rst_n && (r_state == S_IDLE);
`endif

    // abort kills any transfer offered in the same cycle
    assign w_take = bus.in_valid && w_ready && !bus.abort;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_finish    = 1'b0;
`ifdef ONEHOT_STROBE_SKID_EN
        w_pend_full_nxt = r_pend_full;
        w_pend_code_nxt = r_pend_code;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = c_dwell_ld;
                    w_code_nxt  = bus.in;
                end
            end
            S_DRIVE: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else if (GAP > 0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = c_gap_ld;
                end else begin
                    w_finish = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_finish = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase

        if (w_finish) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
`ifdef ONEHOT_STROBE_SKID_EN
            // Chain straight into the next strobe, skipping the IDLE cycle
            if (r_pend_full) begin
                w_state_nxt     = S_DRIVE;
                w_cnt_nxt       = c_dwell_ld;
                w_code_nxt      = r_pend_code;
                w_pend_full_nxt = 1'b0;
            end else if (w_take) begin
                w_state_nxt = S_DRIVE;
                w_cnt_nxt   = c_dwell_ld;
                w_code_nxt  = bus.in;
            end
`endif
        end

`ifdef ONEHOT_STROBE_SKID_EN
        if (!w_finish && w_take && (r_state != S_IDLE)) begin
            w_pend_full_nxt = 1'b1;
            w_pend_code_nxt = bus.in;
        end
`endif

        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
`ifdef ONEHOT_STROBE_SKID_EN
            w_pend_full_nxt = 1'b0;
`endif
        end
    end

    // Outputs are registered from next-state values so the strobe never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_code  <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef ONEHOT_STROBE_SKID_EN
            r_pend_full <= 1'b0;
            r_pend_code <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
            r_out   <= (w_state_nxt == S_DRIVE) ? (c_one << w_code_nxt) : '0;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DRIVE) && (w_cnt_nxt == 8'd0);
`ifdef ONEHOT_STROBE_SKID_EN
            r_pend_full <= w_pend_full_nxt;
            r_pend_code <= w_pend_code_nxt;
`endif
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.out      = r_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_onehot_strobe_decoder.sv
// ============================================================================
// Module      : tb_onehot_strobe_decoder
// Description : Directed self-checking bench; u0 uses DWELL=4/GAP=1,
//               u1 uses DWELL=1/GAP=0. Honours ONEHOT_STROBE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_strobe_decoder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    onehot_strobe_decoder_if #(.IN_W(3)) b0 ();
    onehot_strobe_decoder_if #(.IN_W(3)) b1 ();

    onehot_strobe_decoder #(.IN_W(3), .DWELL(4), .GAP(1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    onehot_strobe_decoder #(.IN_W(3), .DWELL(1), .GAP(0)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] oh_tab [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_idle0(input string tag);
        int n;
        n = 0;
        while ((b0.busy !== 1'b0) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 20), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        oh_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        rst_n = 1'b0;
        b0.in_valid = 1'b0; b0.in = 3'd0; b0.abort = 1'b0;
        b1.in_valid = 1'b0; b1.in = 3'd0; b1.abort = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out", 32'(b0.out), 32'h0);
            chk("rst_busy", 32'(b0.busy), 32'h0);
            chk("rst_done", 32'(b0.done), 32'h0);
            chk("rst_ready", 32'(b0.in_ready), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(b0.in_ready), 32'h1);
        chk("post_rst_out", 32'(b0.out), 32'h0);
        chk("post_rst_busy", 32'(b0.busy), 32'h0);

        // Decode sweep: 4 drive cycles, 1 gap cycle, then IDLE
        for (int c = 0; c < 8; c++) begin
            chk("sweep_ready", 32'(b0.in_ready), 32'h1);
            b0.in_valid = 1'b1;
            b0.in = 3'(c);
            @(negedge clk);
            b0.in_valid = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                chk("sweep_out", 32'(b0.out), 32'(oh_tab[c]));
                chk("sweep_done", 32'(b0.done), 32'(k == 4));
                chk("sweep_busy", 32'(b0.busy), 32'h1);
                @(negedge clk);
            end
            chk("sweep_gap_out", 32'(b0.out), 32'h0);
            chk("sweep_gap_busy", 32'(b0.busy), 32'h1);
            chk("sweep_gap_done", 32'(b0.done), 32'h0);
            @(negedge clk);
            chk("sweep_idle_busy", 32'(b0.busy), 32'h0);
        end

        // Backpressure: in_valid held high with code 5
        b0.in_valid = 1'b1;
        b0.in = 3'd5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
`ifdef ONEHOT_STROBE_SKID_EN
            chk("bp_out", 32'(b0.out), ((i % 5) < 4) ? 32'h20 : 32'h0);
            chk("bp_done", 32'(b0.done), 32'((i % 5) == 3));
`else
            chk("bp_out", 32'(b0.out), ((i % 6) < 4) ? 32'h20 : 32'h0);
            chk("bp_done", 32'(b0.done), 32'((i % 6) == 3));
            chk("bp_ready", 32'(b0.in_ready), 32'((i % 6) == 5));
`endif
        end
        b0.in_valid = 1'b0;
        wait_idle0("bp_drain_timeout");
        @(negedge clk);

        // Abort on the second DRIVE cycle of code 3
        b0.in_valid = 1'b1;
        b0.in = 3'd3;
        @(negedge clk);
        b0.in_valid = 1'b0;
        chk("abort_drive1", 32'(b0.out), 32'h08);
        @(negedge clk);
        chk("abort_drive2", 32'(b0.out), 32'h08);
        b0.abort = 1'b1;
        @(negedge clk);
        b0.abort = 1'b0;
        chk("abort_out", 32'(b0.out), 32'h0);
        chk("abort_ready", 32'(b0.in_ready), 32'h1);
        chk("abort_busy", 32'(b0.busy), 32'h0);
        chk("abort_done", 32'(b0.done), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(b0.done), 32'h0);
            chk("abort_quiet", 32'(b0.out), 32'h0);
        end

        // Abort with a same-cycle transfer in IDLE: transfer dropped
        b0.in_valid = 1'b1;
        b0.in = 3'd6;
        b0.abort = 1'b1;
        @(negedge clk);
        b0.in_valid = 1'b0;
        b0.abort = 1'b0;
        chk("abort_idle_out", 32'(b0.out), 32'h0);
        chk("abort_idle_busy", 32'(b0.busy), 32'h0);
        chk("abort_idle_ready", 32'(b0.in_ready), 32'h1);
        @(negedge clk);
        chk("abort_idle_out2", 32'(b0.out), 32'h0);

        // DWELL=1, GAP=0 stream 2 then 7
        b1.in_valid = 1'b1;
        b1.in = 3'd2;
        @(negedge clk);
        chk("edge_out_2", 32'(b1.out), 32'h04);
        chk("edge_done_2", 32'(b1.done), 32'h1);
        b1.in = 3'd7;
        @(negedge clk);
`ifdef ONEHOT_STROBE_SKID_EN
        chk("edge_out_7", 32'(b1.out), 32'h80);
        chk("edge_done_7", 32'(b1.done), 32'h1);
        b1.in_valid = 1'b0;
`else
        chk("edge_idle_out", 32'(b1.out), 32'h0);
        chk("edge_idle_busy", 32'(b1.busy), 32'h0);
        chk("edge_idle_ready", 32'(b1.in_ready), 32'h1);
        @(negedge clk);
        chk("edge_out_7", 32'(b1.out), 32'h80);
        chk("edge_done_7", 32'(b1.done), 32'h1);
        b1.in_valid = 1'b0;
`endif
        @(negedge clk);
        chk("edge_end_out", 32'(b1.out), 32'h0);
        chk("edge_end_done", 32'(b1.done), 32'h0);

        // Asynchronous reset in the middle of a DRIVE of code 4
        b0.in_valid = 1'b1;
        b0.in = 3'd4;
        @(negedge clk);
        b0.in_valid = 1'b0;
        chk("arst_pre_out", 32'(b0.out), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(b0.out), 32'h0);
        chk("arst_busy", 32'(b0.busy), 32'h0);
        chk("arst_ready", 32'(b0.in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", 32'(b0.in_ready), 32'h1);
        chk("arst_rel_out", 32'(b0.out), 32'h0);
        b0.in_valid = 1'b1;
        b0.in = 3'd4;
        @(negedge clk);
        b0.in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("arst_next_out", 32'(b0.out), 32'h10);
            chk("arst_next_done", 32'(b0.done), 32'(k == 4));
            @(negedge clk);
        end
        chk("arst_next_gap", 32'(b0.out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
